// File: rtl/lcg_rng_arbiter.sv
// lcg_rng_arbiter: one 16-bit linear congruential generator shared by NUM_REQ
// requesters through a round-robin arbiter. Each grant hands out the current
// generator word and advances the generator, so no word is given twice.
// A seed reload, and reset, restart a warm-up phase that discards the first
// WARMUP_CYCLES generator outputs before requests are served.
//
// Handshake: req_i[k] is a level request held by requester k until it sees
// gnt_o[k]. gnt_o is a registered one-hot pulse lasting one cycle. The word in
// rand_data_o belongs to the gnt_o holder in that same cycle, and rand_valid_o
// equals |gnt_o. A requester still asserting req_i after its grant stays
// eligible, but the pointer has already moved past it.
module lcg_rng_arbiter #(
    parameter int              NUM_REQ       = 4,
    parameter int              WIDTH         = 16,
    parameter int              MULT          = 25173,
    parameter int              INCR          = 13849,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(16'h1234),
    parameter int              WARMUP_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               seed_load_i,
    input  logic [WIDTH-1:0]   seed_val_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               rand_valid_o,
    output logic [WIDTH-1:0]   rand_data_o,
    output logic               busy_o,
    output logic               dbg_fsm_o      // 1 = WARM, 0 = RUN
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;
    localparam int WCW = $clog2(WARMUP_CYCLES + 1);

    localparam logic [WIDTH-1:0] MULT_W = WIDTH'(MULT);
    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);
    localparam logic [PW:0]      NR_W   = PW1'(NUM_REQ);
    localparam logic [WCW-1:0]   WU_W   = WCW'(WARMUP_CYCLES);

    typedef enum logic {
        RUN_S  = 1'b0,
        WARM_S = 1'b1
    } fsm_t;

    fsm_t               fsm_q;
    logic [WIDTH-1:0]   state_q;
    logic [WCW-1:0]     wcnt_q;
    logic [PW-1:0]      ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               valid_q;
    logic [WIDTH-1:0]   data_q;

    logic [WIDTH-1:0]   state_d;
    logic               found_d;
    logic [PW-1:0]      winner_d;
    logic [PW-1:0]      ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [PW:0]        cand;
    logic [PW:0]        ptr_inc;

    // Generator step: product truncated to WIDTH bits, wraps naturally.
    always_comb begin
        state_d = state_q * MULT_W + INCR_W;
    end

    // Round-robin search: first asserted request at or after ptr_q, wrapping.
    always_comb begin
        found_d  = 1'b0;
        winner_d = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + PW1'(i);
            if (cand >= NR_W) begin
                cand = cand - NR_W;
            end
            if (!found_d && req_i[cand[PW-1:0]]) begin
                found_d  = 1'b1;
                winner_d = cand[PW-1:0];
            end
        end
    end

    // Grant vector and the pointer position just past the winner.
    always_comb begin
        gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_d;
        ptr_inc = {1'b0, winner_d} + PW1'(1);
        if (ptr_inc == NR_W) begin
            ptr_inc = '0;
        end
        ptr_d = ptr_inc[PW-1:0];
    end

    // Control FSM: warm-up discard, then serve one request per cycle; seed wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= WARM_S;
            state_q <= SEED_DEFAULT;
            wcnt_q  <= WU_W;
            ptr_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            gnt_q   <= '0;
            valid_q <= 1'b0;
            case (fsm_q)
                WARM_S: begin
                    if (seed_load_i) begin
                        state_q <= seed_val_i;
                        wcnt_q  <= WU_W;
                    end else begin
                        state_q <= state_d;
                        wcnt_q  <= wcnt_q - WCW'(1);
                        if (wcnt_q == WCW'(1)) begin
                            fsm_q <= RUN_S;
                        end
                    end
                end
                RUN_S: begin
                    if (seed_load_i) begin
                        state_q <= seed_val_i;
                        wcnt_q  <= WU_W;
                        fsm_q   <= WARM_S;
                    end else if (found_d) begin
                        gnt_q   <= gnt_d;
                        valid_q <= 1'b1;
                        data_q  <= state_q;
                        state_q <= state_d;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    fsm_q <= WARM_S;
                end
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign rand_valid_o = valid_q;
    assign rand_data_o  = data_q;
    assign busy_o       = (fsm_q == WARM_S);
    assign dbg_fsm_o    = fsm_q;

endmodule

// File: tb/tb_lcg_rng_arbiter.sv
// Bench for lcg_rng_arbiter (NUM_REQ=4, WARMUP_CYCLES=1): a vector table for
// the directed scenarios, hand sequences for seed-in-RUN and mid-grant reset,
// and a randomized phase, all shadowed by a cycle-level reference model.
module tb_lcg_rng_arbiter;

  localparam int NR = 4;
  localparam int WU = 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        sl;
  logic [15:0] sv;
  logic [3:0]  req;
  wire  [3:0]  gnt;
  wire         valid;
  wire  [15:0] data;
  wire         busy;
  wire         dbg_fsm;

  always #5 clk = ~clk;

  lcg_rng_arbiter #(
    .NUM_REQ(NR), .WIDTH(16), .MULT(25173), .INCR(13849),
    .SEED_DEFAULT(16'h1234), .WARMUP_CYCLES(WU)
  ) dut (
    .clk_i(clk), .rst_i(rst), .seed_load_i(sl), .seed_val_i(sv), .req_i(req),
    .gnt_o(gnt), .rand_valid_o(valid), .rand_data_o(data), .busy_o(busy),
    .dbg_fsm_o(dbg_fsm)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lcg(input logic [15:0] s);
    int unsigned t;
    t = int'(s) * 25173 + 13849;
    return 16'(t % 65536);
  endfunction

  logic [15:0] m_state;
  bit          m_busy;
  int          m_wcnt;
  int          m_ptr;
  logic [3:0]  m_gnt;
  logic [15:0] m_last;
  logic [15:0] exp_q[$];

  function automatic void model_reset();
    m_state = 16'h1234;
    m_busy  = 1'b1;
    m_wcnt  = WU;
    m_ptr   = 0;
    m_gnt   = 4'b0;
    m_last  = 16'h0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic s_l, input logic [15:0] s_v, input logic [3:0] rq);
    int w;
    w = -1;
    m_gnt = 4'b0;
    if (m_busy) begin
      if (s_l) begin
        m_state = s_v;
        m_wcnt  = WU;
      end else begin
        m_state = lcg(m_state);
        m_wcnt  = m_wcnt - 1;
        if (m_wcnt == 0) m_busy = 1'b0;
      end
    end else if (s_l) begin
      m_state = s_v;
      m_wcnt  = WU;
      m_busy  = 1'b1;
    end else if (rq != 4'b0) begin
      for (int k = 0; k < NR; k++)
        if (w < 0 && rq[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
      m_gnt = 4'(1 << w);
      exp_q.push_back(m_state);
      m_state = lcg(m_state);
      m_ptr   = (w + 1) % NR;
    end
  endfunction

  // ---------------- driver / scoreboard ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_step(sl, sv, req);
    check("mdl_gnt", 32'(gnt), 32'(m_gnt));
    check("mdl_valid", 32'(valid), 32'(m_gnt != 4'b0));
    check("mdl_busy", 32'(busy), 32'(m_busy));
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("mdl_unexpected_word", 32'(data), 32'hFFFF_FFFF);
      end else begin
        m_last = exp_q.pop_front();
        check("mdl_data", 32'(data), 32'(m_last));
      end
    end else begin
      check("mdl_hold", 32'(data), 32'(m_last));
    end
  endtask

  task automatic drive(input logic s_l, input logic [15:0] s_v, input logic [3:0] rq);
    sl  = s_l;
    sv  = s_v;
    req = rq;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sl;
    logic [15:0] sv;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        busy;
    logic        chk_d;
    logic [15:0] d;
  } vec_t;

  vec_t        tbl[20];
  logic [15:0] got8[$];
  logic [15:0] sv_r;
  int          dups;

  initial begin
    // release from reset, idle
    tbl[0]  = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0};
    tbl[1]  = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0};
    // seed 0x0001, warm-up, sole requester 2
    tbl[2]  = '{1'b1, 16'h0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0};
    tbl[3]  = '{1'b0, 16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 16'h0};
    tbl[4]  = '{1'b0, 16'h0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 16'h986E};
    tbl[5]  = '{1'b0, 16'h0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 16'hEE9F};
    // bring ptr to 0, then all four requesting for 8 cycles
    tbl[6]  = '{1'b0, 16'h0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 16'h0};
    tbl[7]  = '{1'b0, 16'h0000, 4'b1111, 4'b0001, 1'b0, 1'b0, 16'h0};
    tbl[8]  = '{1'b0, 16'h0000, 4'b1111, 4'b0010, 1'b0, 1'b0, 16'h0};
    tbl[9]  = '{1'b0, 16'h0000, 4'b1111, 4'b0100, 1'b0, 1'b0, 16'h0};
    tbl[10] = '{1'b0, 16'h0000, 4'b1111, 4'b1000, 1'b0, 1'b0, 16'h0};
    tbl[11] = '{1'b0, 16'h0000, 4'b1111, 4'b0001, 1'b0, 1'b0, 16'h0};
    tbl[12] = '{1'b0, 16'h0000, 4'b1111, 4'b0010, 1'b0, 1'b0, 16'h0};
    tbl[13] = '{1'b0, 16'h0000, 4'b1111, 4'b0100, 1'b0, 1'b0, 16'h0};
    tbl[14] = '{1'b0, 16'h0000, 4'b1111, 4'b1000, 1'b0, 1'b0, 16'h0};
    // bring ptr to 2, then wrap-around between requesters 3 and 1
    tbl[15] = '{1'b0, 16'h0000, 4'b0010, 4'b0010, 1'b0, 1'b0, 16'h0};
    tbl[16] = '{1'b0, 16'h0000, 4'b1010, 4'b1000, 1'b0, 1'b0, 16'h0};
    tbl[17] = '{1'b0, 16'h0000, 4'b1010, 4'b0010, 1'b0, 1'b0, 16'h0};
    tbl[18] = '{1'b0, 16'h0000, 4'b1010, 4'b1000, 1'b0, 1'b0, 16'h0};
    tbl[19] = '{1'b0, 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0};

    // reset state
    rst = 1'b1;
    drive(1'b0, 16'h0, 4'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    rst = 1'b0;

    // table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].sl, tbl[i].sv, tbl[i].req);
      tick();
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].gnt != 4'b0));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].chk_d) check($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].d));
      if (i >= 7 && i <= 14 && valid) got8.push_back(data);
    end
    dups = 0;
    for (int a = 0; a < got8.size(); a++)
      for (int b = a + 1; b < got8.size(); b++)
        if (got8[a] == got8[b]) dups++;
    check("rr8_count", 32'(got8.size()), 32'd8);
    check("rr8_distinct_dups", 32'(dups), 32'd0);

    // seed_load together with a request in RUN
    sv_r = 16'($urandom);
    drive(1'b1, sv_r, 4'b0001);
    tick();
    check("seed_run_gnt", 32'(gnt), 32'h0);
    check("seed_run_busy", 32'(busy), 32'h1);
    drive(1'b0, 16'h0, 4'b0001);
    tick();
    check("seed_warm_gnt", 32'(gnt), 32'h0);
    check("seed_warm_busy", 32'(busy), 32'h0);
    tick();
    check("seed_first_gnt", 32'(gnt), 32'h1);
    check("seed_first_word", 32'(data), 32'(lcg(sv_r)));

    // async reset while a grant is showing
    tick();
    check("pre_rst_valid", 32'(valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_data", 32'(data), 32'h0);
    check("arst_busy", 32'(busy), 32'h1);
    model_reset();
    drive(1'b0, 16'h0, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_gnt", 32'(gnt), 32'h0);
    drive(1'b0, 16'h0, 4'b0001);
    tick();
    check("post_rst_word", 32'(data), 32'(lcg(16'h1234)));

    // randomized traffic: requests held until granted, occasional reseed
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 19) == 0), 16'($urandom),
            (req & ~m_gnt) | 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) req = req & ~m_gnt;
      tick();
    end
    drive(1'b0, 16'h0, 4'b0000);
    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
